// File: rtl/arb_pkg.sv
// Shared types and defaults for the data register arbiter.
// Holds the FSM state type, default sizing constants and an index-width helper.
package arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } arb_state_e;

    localparam int unsigned DefNReq  = 4;
    localparam int unsigned DefDataW = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
// Produces the winner as one-hot and as an index, with valid_o when any request is set.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    localparam int unsigned IdxW = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  start_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IdxW'((32'(start_i) + k) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_reg_arbiter.sv
// Round-robin arbiter guarding one shared data register; the grantee may write it.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive owned cycles.
module data_reg_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DefNReq,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IdxW    = idx_width(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        lock_i,
    input  logic [N_REQ-1:0]        wr_i,
    input  logic [N_REQ*DATA_W-1:0] wdata_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [DATA_W-1:0]       data_out_o,
    output logic [IdxW-1:0]         owner_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    arb_state_e        state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [DATA_W-1:0] data_q;
    logic [IdxW-1:0]   owner_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   ptr_d;
    logic              busy_q;
    logic              timeout_q;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;
    logic              own_release;
    logic              hold_expire;

    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_wdata
        assign wdata_arr[i] = wdata_i[i*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i    (req_i),
        .start_i  (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Next search begins just past the winner.
    assign ptr_d       = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign own_release = !req_i[owner_q] || !lock_i[owner_q];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    logic [HoldW-1:0] hold_cnt_q;

    assign hold_expire = !own_release && (hold_cnt_q == HoldW'(MAX_HOLD));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            hold_cnt_q <= pick_valid ? HoldW'(1) : '0;
        end else if (own_release || hold_expire) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign hold_expire     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            data_q    <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q <= StOwn;
                        gnt_q   <= pick_onehot;
                        owner_q <= pick_idx;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                    end
                end
                StOwn: begin
                    // A write in the releasing cycle still lands.
                    if (wr_i[owner_q]) begin
                        data_q <= wdata_arr[owner_q];
                    end
                    if (own_release || hold_expire) begin
                        state_q   <= StIdle;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= hold_expire;
                    end
                end
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign data_out_o = data_q;
    assign owner_o    = owner_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_data_reg_arbiter.sv
// Directed bench for data_reg_arbiter; grant expectations flow through a scoreboard queue.
// Covers both ARB_TIMEOUT_EN builds in the hold test.
module tb_data_reg_arbiter;

    localparam int unsigned NReq  = 4;
    localparam int unsigned DataW = 16;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NReq-1:0]         req_i;
    logic [NReq-1:0]         lock_i;
    logic [NReq-1:0]         wr_i;
    logic [NReq*DataW-1:0]   wdata_i;
    logic [NReq-1:0]         gnt_o;
    logic [DataW-1:0]        data_out_o;
    logic [1:0]              owner_o;
    logic                    busy_o;
    logic                    timeout_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];

    always #5 clk_i = ~clk_i;

    data_reg_arbiter #(
        .N_REQ    (NReq),
        .DATA_W   (DataW),
        .MAX_HOLD (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .lock_i     (lock_i),
        .wr_i       (wr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .data_out_o (data_out_o),
        .owner_o    (owner_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag);
        int e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'(gnt_o), 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(gnt_o), 64'd1 << e);
            check({tag, "_owner"}, 64'(owner_o), 64'(e));
            check({tag, "_busy"}, 64'(busy_o), 64'd1);
        end
    endtask

    task automatic set_wdata(input int idx, input logic [DataW-1:0] v);
        wdata_i[idx*DataW +: DataW] = v;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        req_i   = '0;
        lock_i  = '0;
        wr_i    = '0;
        wdata_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
    endtask

    initial begin
        logic [NReq-1:0] prev_gnt;
        int hold;

        // Reset values
        do_reset();
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_data", 64'(data_out_o), 64'd0);
        check("rst_owner", 64'(owner_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);

        // Single unlocked write by requester 1
        req_i = 4'b0010;
        wr_i  = 4'b0010;
        set_wdata(1, 16'd12);
        exp_q.push_back(1);
        tick();
        check_grant("w1_gnt");
        tick();
        check("w1_data", 64'(data_out_o), 64'd12);
        check("w1_release", 64'(gnt_o), 64'd0);
        req_i = '0;
        wr_i  = '0;
        tick();
        check("w1_hold_data", 64'(data_out_o), 64'd12);
        check("w1_hold_owner", 64'(owner_o), 64'd1);

        // Round robin over all requesters from reset
        do_reset();
        req_i = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        prev_gnt = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (prev_gnt != '0) check("rr_gap", 64'(gnt_o), 64'd0);
            if (gnt_o != '0) check_grant("rr_gnt");
            prev_gnt = gnt_o;
        end
        req_i = '0;
        tick();
        check("rr_sb_empty", 64'(exp_q.size()), 64'd0);

        // Locked owner 2: only the owner's write lands, others cannot disturb
        req_i  = 4'b0100;
        lock_i = 4'b0100;
        exp_q.push_back(2);
        tick();
        check_grant("own2_gnt");
        wr_i = 4'b0101;
        set_wdata(0, 16'd3);
        set_wdata(2, 16'd1);
        tick();
        check("own2_data", 64'(data_out_o), 64'd1);
        wr_i = 4'b0001;
        tick();
        check("own2_foreign_wr", 64'(data_out_o), 64'd1);
        check("own2_locked", 64'(gnt_o), 64'h4);
        req_i = 4'b1111;
        wr_i  = '0;
        tick();
        check("own2_others_req", 64'(gnt_o), 64'h4);
        lock_i = '0;
        tick();
        check("own2_release", 64'(gnt_o), 64'd0);
        exp_q.push_back(3);
        tick();
        check_grant("own2_next_rr");
        req_i = '0;
        tick();
        check("own2_after_gnt", 64'(gnt_o), 64'd0);
        check("own2_owner_held", 64'(owner_o), 64'd3);

        // Locked hold on requester 3
        do_reset();
        req_i  = 4'b1000;
        lock_i = 4'b1000;
        exp_q.push_back(3);
        tick();
        check_grant("hold_gnt");
        hold = 1;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt_o != 4'b1000) begin
                check("hold_timeout_pulse", 64'(timeout_o), 64'd1);
                check("hold_gnt_drop", 64'(gnt_o), 64'd0);
                break;
            end
            check("hold_no_timeout", 64'(timeout_o), 64'd0);
            hold++;
        end
        check("hold_cycles", 64'(hold), 64'd8);
        tick();
        check("hold_timeout_one_cycle", 64'(timeout_o), 64'd0);
`else
        for (int c = 0; c < 49; c++) begin
            tick();
            if (gnt_o == 4'b1000 && timeout_o == 1'b0) hold++;
        end
        check("hold_cycles", 64'(hold), 64'd50);
        check("hold_timeout_tied", 64'(timeout_o), 64'd0);
`endif
        req_i  = '0;
        lock_i = '0;
        repeat (2) tick();
        check("hold_end_gnt", 64'(gnt_o), 64'd0);

        // Reset during OWN discards the concurrent write
        do_reset();
        req_i  = 4'b0100;
        lock_i = 4'b0100;
        exp_q.push_back(2);
        tick();
        check_grant("mid_gnt");
        wr_i = 4'b0100;
        set_wdata(2, 16'h0011);
        tick();
        check("mid_data", 64'(data_out_o), 64'h11);
        set_wdata(2, 16'h0055);
        rst_i = 1'b1;
        tick();
        check("mid_rst_gnt", 64'(gnt_o), 64'd0);
        check("mid_rst_data", 64'(data_out_o), 64'd0);
        check("mid_rst_owner", 64'(owner_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        rst_i  = 1'b0;
        req_i  = 4'b1111;
        lock_i = '0;
        wr_i   = '0;
        exp_q.push_back(0);
        tick();
        check_grant("mid_next_gnt");
        req_i = '0;
        tick();

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_reg_arbiter.md
DATA_REG_ARBITER -- requirements
Module: data_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, default 16, width of shared data register.
REQ-003 Parameter MAX_HOLD, default 8, max consecutive OWN cycles (used only with ARB_TIMEOUT_EN).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  N_REQ  per-requester access request.
REQ-007 lock  in  N_REQ  per-requester hold-grant request.
REQ-008 wr  in  N_REQ  per-requester write strobe.
REQ-009 wdata  in  N_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 gnt  out  N_REQ  one-hot grant, registered.
REQ-011 data_out  out  DATA_W  shared register contents.
REQ-012 owner  out  clog2(N_REQ)  index of current/last grantee.
REQ-013 busy  out  1  high while in OWN.
REQ-014 timeout  out  1  one-cycle pulse on forced release.

Function
REQ-015 FSM SHALL have states IDLE and OWN only.
REQ-016 IDLE: gnt=0; if any req bit high, winner chosen round-robin, gnt/owner registered, next state OWN (req-to-gnt latency 1 cycle).
REQ-017 Round-robin SHALL search from index (last owner+1) mod N_REQ upward with wrap; after reset search starts at 0.
REQ-018 OWN: gnt SHALL stay one-hot at owner; busy=1.
REQ-019 In any OWN cycle with wr[owner]=1, data_out SHALL take wdata[owner] at next edge (write latency 1).
REQ-020 wr from non-granted requesters, and any wr in IDLE, SHALL be ignored.
REQ-021 OWN releases (next state IDLE, gnt=0 next cycle) when req[owner]=0 or lock[owner]=0; a write in the releasing cycle is still performed.
REQ-022 Without lock, a grant SHALL last exactly one cycle; release always inserts one IDLE cycle before the next grant.
REQ-023 Requesters other than owner SHALL not affect OWN; their requests are served in round-robin order afterwards.
REQ-024 data_out SHALL hold its value when not written; owner SHALL hold after release.

Reset
REQ-025 On rst=1 at a clock edge: state IDLE, gnt=0, data_out=0, owner=0, busy=0, timeout=0, hold counter=0, round-robin pointer=0.
REQ-026 Reset during OWN SHALL drop gnt at that edge and discard any concurrent write.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: counter counts OWN cycles; when MAX_HOLD cycles have elapsed, release is forced regardless of lock, timeout pulses 1 cycle with gnt falling.
REQ-028 ARB_TIMEOUT_EN undefined: no counter; lock holds grant indefinitely; timeout tied 0; port list unchanged.

Structure
REQ-029 Package arb_pkg SHALL hold the state typedef (IDLE, OWN) and default DATA_W/N_REQ constants.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_priority_pick (inputs req vector and start index, outputs one-hot and index, valid).

Verification
REQ-031 rst 3 cycles, release -> gnt=0, data_out=0, owner=0, busy=0.
REQ-032 req=4'b0010, wr[1]=1, wdata[1]=16'd12, lock=0 -> gnt=4'b0010 one cycle after req, data_out=12 the cycle after, then gnt=0.
REQ-033 req=4'b1111 held, lock=0 -> grants cycle 0,1,2,3,0 each separated by one IDLE cycle.
REQ-034 Owner 2 granted, wr[0]=1 wdata[0]=16'd3 and wr[2]=1 wdata[2]=16'd1 -> data_out=1 only.
REQ-035 With ARB_TIMEOUT_EN, MAX_HOLD=8, req[3]=lock[3]=1 held -> gnt=4'b1000 exactly 8 cycles, timeout pulse on release; without macro, grant held for 50 cycles.
REQ-036 rst asserted mid-OWN with wr[owner]=1 -> next cycle gnt=0, data_out=0, next grant starts at requester 0.
